writeback_stage: RTL

- Final pipeline stage; sits directly downstream of the memory-access stage and consumes its aluresult/ldresult.
- Selects the writeback value and buffers completed instructions in a 2-entry skid FIFO.
- Drains the FIFO into the register-file write port under a ready/valid handshake.
- Exposes a forwarding lookup over all pending entries so decode/execute can bypass un-retired results.

---
 rtl/writeback_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: selects the result, buffers up to two completed instructions and
// drains them in order to the register file. Optional retire counter: WB_RETIRE_CNT_EN.
module writeback_stage #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 4,
   parameter int CALL_REG = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              isld,
   input  logic              iscall,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] rd,
   input  logic [DATA_W-1:0] aluresult,
   input  logic [DATA_W-1:0] ldresult,
   input  logic [DATA_W-1:0] pc,
   input  logic              flush,
   output logic              rf_we,
   input  logic              rf_ready,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [REG_AW-1:0] hz_addr,
   output logic              hz_hit,
   output logic [DATA_W-1:0] hz_data,
`ifdef WB_RETIRE_CNT_EN
   output logic [31:0]       retire_count,
`endif
   output logic              busy
);

   typedef struct packed {
      logic              wb_en;
      logic [REG_AW-1:0] waddr;
      logic [DATA_W-1:0] wdata;
   } entry_t;

   localparam logic [DATA_W-1:0] PC_INC   = {{(DATA_W-3){1'b0}}, 3'd4};
   localparam logic [REG_AW-1:0] LINK_REG = REG_AW'(CALL_REG);

   // A call writes its link address and takes priority over a load.
   function automatic entry_t select_entry(
      input logic              call_i,
      input logic              ld_i,
      input logic              we_i,
      input logic [REG_AW-1:0] rd_i,
      input logic [DATA_W-1:0] alu_i,
      input logic [DATA_W-1:0] ld_data_i,
      input logic [DATA_W-1:0] pc_i
   );
      entry_t e;
      e.wb_en = we_i;
      if (call_i) begin
         e.waddr = LINK_REG;
         e.wdata = pc_i + PC_INC;
      end else if (ld_i) begin
         e.waddr = rd_i;
         e.wdata = ld_data_i;
      end else begin
         e.waddr = rd_i;
         e.wdata = alu_i;
      end
      return e;
   endfunction

   function automatic logic fwd_match(
      input logic              valid_i,
      input entry_t            e_i,
      input logic [REG_AW-1:0] addr_i
   );
      return valid_i & e_i.wb_en & (e_i.waddr == addr_i);
   endfunction

   entry_t      ent_r [2];
   logic [1:0]  valid_r;
   logic        wptr_r;
   logic        rptr_r;
   logic [1:0]  count_r;

   entry_t      new_s;
   entry_t      head_s;
   logic        head_valid_s;
   logic        push_s;
   logic        pop_s;
   logic        yng_s;

   // Head-of-queue view, handshake decode and register-file drive.
   always_comb begin
      new_s        = select_entry(iscall, isld, wb_en, rd, aluresult, ldresult, pc);
      head_valid_s = valid_r[rptr_r];
      head_s       = ent_r[rptr_r];
      in_ready     = (count_r < 2'd2);
      push_s       = in_valid & in_ready;
      // Non-writing entries retire without waiting on the register file.
      pop_s        = head_valid_s & (~head_s.wb_en | rf_ready);
      rf_we        = head_valid_s & head_s.wb_en;
      busy         = (count_r != 2'd0);
      if (head_valid_s) begin
         rf_waddr = head_s.waddr;
         rf_wdata = head_s.wdata;
      end else begin
         rf_waddr = {REG_AW{1'b0}};
         rf_wdata = {DATA_W{1'b0}};
      end
   end

   // Forwarding lookup: the slot behind the write pointer holds the youngest entry.
   always_comb begin
      yng_s   = ~wptr_r;
      hz_hit  = 1'b0;
      hz_data = {DATA_W{1'b0}};
      if (fwd_match(valid_r[yng_s], ent_r[yng_s], hz_addr)) begin
         hz_hit  = 1'b1;
         hz_data = ent_r[yng_s].wdata;
      end else if (fwd_match(valid_r[wptr_r], ent_r[wptr_r], hz_addr)) begin
         hz_hit  = 1'b1;
         hz_data = ent_r[wptr_r].wdata;
      end else begin
         hz_hit  = 1'b0;
         hz_data = {DATA_W{1'b0}};
      end
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_r[0] <= '{wb_en: 1'b0, waddr: {REG_AW{1'b0}}, wdata: {DATA_W{1'b0}}};
         ent_r[1] <= '{wb_en: 1'b0, waddr: {REG_AW{1'b0}}, wdata: {DATA_W{1'b0}}};
         valid_r  <= 2'b00;
         wptr_r   <= 1'b0;
         rptr_r   <= 1'b0;
         count_r  <= 2'd0;
      end else if (flush) begin
         valid_r  <= 2'b00;
         wptr_r   <= 1'b0;
         rptr_r   <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (pop_s) begin
            valid_r[rptr_r] <= 1'b0;
            rptr_r          <= ~rptr_r;
         end else begin
            rptr_r          <= rptr_r;
         end
         if (push_s) begin
            ent_r[wptr_r]   <= new_s;
            valid_r[wptr_r] <= 1'b1;
            wptr_r          <= ~wptr_r;
         end else begin
            wptr_r          <= wptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

`ifdef WB_RETIRE_CNT_EN
   // Retired-instruction counter; a handshake in a flush cycle still retires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_count <= 32'd0;
      end else if (pop_s) begin
         retire_count <= retire_count + 32'd1;
      end else begin
         retire_count <= retire_count;
      end
   end
`endif

endmodule
